hazard_scoreboard_unit: RTL and testbench
=========================================

// Module: hazard_scoreboard_unit
// PURPOSE
//  Next-gen pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W). Generates per-port E-stage
//  forwarding selects, load-use and structural stalls, and per-stage stall/flush. Adds a one-entry long-op
//  scoreboard (div/mult) with FSM and watchdog so D-stage readers of an in-flight long-op result stall
//  instead of relying on whole-pipe freeze.
// PARAMETERS
//  NUM_RD_PORTS  2   source operands checked per instruction (rs, rt, ...)
//  REG_AW        5   register address width; address 0 is hard-wired zero
//  WDOG_MAX      40  max cycles a long op may stay busy before lat_err is raised
// PORTS
//  clk             in   1                      clock
//  rst             in   1                      synchronous, active-high reset
//  src_addrD       in   NUM_RD_PORTS*REG_AW    D-stage source addresses, port p at [p*REG_AW +: REG_AW]
//  src_addrE       in   NUM_RD_PORTS*REG_AW    E-stage source addresses
//  wr_enE/M/W      in   1 each                 stage writes a GPR
//  wr_addrE/M/W    in   REG_AW each            destination in that stage
//  is_loadE        in   1                      E-stage instruction is a load (data available only in W)
//  long_startE     in   1                      E-stage instruction starts a long op (div/mult)
//  long_dstE       in   REG_AW                 long op destination
//  long_done       in   1                      long-op unit result valid this cycle
//  i_stall,d_stall in   1 each                 cache miss stalls
//  flush_jumpE     in   1                      jump-conflict redirect from E
//  flush_predM     in   1                      branch mispredict from M
//  flush_excM      in   1                      exception/eret from M
//  fwd_selE        out  NUM_RD_PORTS*2         per port: 00 regfile, 01 M, 10 W
//  stallF..stallW  out  1 each                 stage hold
//  flushF..flushW  out  1 each                 stage bubble insert
//  long_busy       out  1                      scoreboard occupied
//  lat_err         out  1                      sticky watchdog error
// BEHAVIOUR
//  Reset: FSM IDLE, busy_dst=0, wdog=0, lat_err=0; outputs derive from inputs only (all stall/flush 0 when inputs idle).
//  Forwarding (comb): port p src!=0 and wr_enM and match wr_addrM -> 01; else wr_enW match -> 10; else 00. M beats W.
//  load_use = is_loadE & wr_enE & any D port (src!=0) == wr_addrE.
//  sb_hit = long_busy & any D port (src!=0) == busy_dst.
//  struct  = long_startE & long_busy & ~long_done (second long op while one in flight).
//  hard = i_stall|d_stall|struct.
//  stallW=stallM=hard; stallE=hard; stallD=hard|load_use|sb_hit;
//  stallF=~flush_excM & (hard | ((load_use|sb_hit) & ~flush_predM)).
//  flushF=0; flushW=0; flushM=flush_excM;
//  flushE=flush_excM | (flush_predM&~hard) | ((load_use|sb_hit)&~hard);
//  flushD=flush_excM | (flush_predM&~hard) | (flush_jumpE&~hard&~load_use&~sb_hit).
//  FSM IDLE->BUSY: long_startE & ~stallE & ~flushE & ~flush_excM; latch busy_dst=long_dstE (0 if dst is r0).
//  BUSY->IDLE: long_done (same cycle busy_dst cleared; done+new start same cycle -> stays BUSY, new dst latched).
//  BUSY->IDLE: flush_excM (aborted op; a long_done in the following cycle is ignored).
//  Watchdog: counts in BUSY, clears on leaving BUSY; reaching WDOG_MAX sets lat_err (sticky until rst), FSM unchanged.
//  rst mid-op: FSM IDLE immediately, scoreboard empty, any later long_done ignored while IDLE.
// CONFIGURATION
//  HAZARD_PERF_CNT_EN defined: adds outputs perf_lu_cnt, perf_sb_cnt, perf_mem_cnt (32b each, wrap at 2^32)
//   counting cycles with load_use, sb_hit, i_stall|d_stall; cleared by rst.
//  Undefined: counters and ports absent; all other behaviour identical.
// STRUCTURE
//  Shared package hazard_pkg: fwd_sel_t (FWD_NONE=2'b00, FWD_MEM=2'b01, FWD_WB=2'b10), long_state_t (LS_IDLE, LS_BUSY).
//  One sub-module: hazard_fwd_port (one source address vs M/W writers -> fwd_sel_t), instantiated NUM_RD_PORTS times.
//  FSM, watchdog and stall/flush logic stay in the top.
// TESTING
//  1 ALU RAW: wr_enM=1,wr_addrM=8, src_addrE port0=8 and wr_enW=1,wr_addrW=8 -> fwd port0=01; r0 source -> 00.
//  2 Load-use: is_loadE=1,wr_addrE=9, src_addrD port1=9 -> stallF=stallD=1, flushE=1 one cycle; next cycle fwd port1=10.
//  3 Long op: start dst=2 at t0, D reads r2 t1..t5 -> stallD=1, flushE=1; long_done t5 -> stall released t6.
//  4 Structural: second long_startE while BUSY -> stallE..W=1 until long_done; then FSM re-enters BUSY with new dst.
//  5 Exception abort: BUSY then flush_excM -> IDLE, flushD/E/M=1, stallF=0; stray long_done next cycle leaves IDLE.
//  6 Watchdog/reset: hold BUSY WDOG_MAX cycles -> lat_err=1 sticky; rst in BUSY -> long_busy=0, lat_err=0 next cycle.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types for the hazard scoreboard unit.
// Optional feature macro: HAZARD_PERF_CNT_EN (adds stall performance counters).
package hazard_pkg;

  localparam int unsigned NUM_RD_PORTS_DEF = 2;
  localparam int unsigned REG_AW_DEF       = 5;
  localparam int unsigned WDOG_MAX_DEF     = 40;
  localparam int unsigned PERF_W           = 32;

  typedef enum logic [1:0] {
    FWD_NONE = 2'b00,
    FWD_MEM  = 2'b01,
    FWD_WB   = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    LS_IDLE = 1'b0,
    LS_BUSY = 1'b1
  } long_state_t;

endpackage

// File: rtl/hazard_scoreboard_unit_if.sv
// Pipeline <-> hazard unit signal bundle; master is the pipeline, slave the hazard unit.
// HAZARD_PERF_CNT_EN adds the perf counter outputs.
interface hazard_scoreboard_unit_if
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int unsigned REG_AW       = REG_AW_DEF
);
  logic [NUM_RD_PORTS*REG_AW-1:0] src_addrD;
  logic [NUM_RD_PORTS*REG_AW-1:0] src_addrE;
  logic              wr_enE, wr_enM, wr_enW;
  logic [REG_AW-1:0] wr_addrE, wr_addrM, wr_addrW;
  logic              is_loadE;
  logic              long_startE;
  logic [REG_AW-1:0] long_dstE;
  logic              long_done;
  logic              i_stall, d_stall;
  logic              flush_jumpE, flush_predM, flush_excM;
  logic [NUM_RD_PORTS*2-1:0] fwd_selE;
  logic stallF, stallD, stallE, stallM, stallW;
  logic flushF, flushD, flushE, flushM, flushW;
  logic long_busy;
  logic lat_err;
`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] perf_lu_cnt, perf_sb_cnt, perf_mem_cnt;
`endif

  modport master (
    output src_addrD, src_addrE, wr_enE, wr_enM, wr_enW, wr_addrE, wr_addrM, wr_addrW,
           is_loadE, long_startE, long_dstE, long_done, i_stall, d_stall,
           flush_jumpE, flush_predM, flush_excM,
    input  fwd_selE, stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW, long_busy, lat_err
`ifdef HAZARD_PERF_CNT_EN
    , input perf_lu_cnt, perf_sb_cnt, perf_mem_cnt
`endif
  );

  modport slave (
    input  src_addrD, src_addrE, wr_enE, wr_enM, wr_enW, wr_addrE, wr_addrM, wr_addrW,
           is_loadE, long_startE, long_dstE, long_done, i_stall, d_stall,
           flush_jumpE, flush_predM, flush_excM,
    output fwd_selE, stallF, stallD, stallE, stallM, stallW,
           flushF, flushD, flushE, flushM, flushW, long_busy, lat_err
`ifdef HAZARD_PERF_CNT_EN
    , output perf_lu_cnt, perf_sb_cnt, perf_mem_cnt
`endif
  );

endinterface

// File: rtl/hazard_fwd_port.sv
// One E-stage source operand against the M and W writers; M (younger) wins over W.
module hazard_fwd_port
  import hazard_pkg::*;
#(
  parameter int unsigned REG_AW = REG_AW_DEF
) (
  input  logic [REG_AW-1:0] src_addr,
  input  logic              wr_en_m,
  input  logic [REG_AW-1:0] wr_addr_m,
  input  logic              wr_en_w,
  input  logic [REG_AW-1:0] wr_addr_w,
  output fwd_sel_t          fwd_sel_c
);

  always_comb begin
    fwd_sel_c = FWD_NONE;
    if (src_addr != '0) begin
      if (wr_en_m && (wr_addr_m == src_addr))      fwd_sel_c = FWD_MEM;
      else if (wr_en_w && (wr_addr_w == src_addr)) fwd_sel_c = FWD_WB;
    end
  end

endmodule

// File: rtl/hazard_scoreboard_unit.sv
// 5-stage pipeline hazard controller with a one-entry long-op scoreboard and watchdog.
// HAZARD_PERF_CNT_EN adds load-use / scoreboard / memory stall cycle counters.
module hazard_scoreboard_unit
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_RD_PORTS = NUM_RD_PORTS_DEF,
  parameter int unsigned REG_AW       = REG_AW_DEF,
  parameter int unsigned WDOG_MAX     = WDOG_MAX_DEF
) (
  input logic clk,
  input logic rst,
  hazard_scoreboard_unit_if.slave hz
);

  localparam int unsigned WDOG_W = $clog2(WDOG_MAX + 1);

  long_state_t       state, state_nxt;
  logic [REG_AW-1:0] busy_dst, busy_dst_nxt;
  logic [WDOG_W-1:0] wdog;
  logic              lat_err;
  logic              long_busy, load_use, sb_hit, struct_haz, hard, start_ok, relaunch;
  logic              lu_match, sb_match;
  fwd_sel_t          sel [NUM_RD_PORTS];
  logic [NUM_RD_PORTS*2-1:0] fwd_flat;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_fwd
    hazard_fwd_port #(.REG_AW(REG_AW)) u_port (
      .src_addr (hz.src_addrE[p*REG_AW +: REG_AW]),
      .wr_en_m  (hz.wr_enM),
      .wr_addr_m(hz.wr_addrM),
      .wr_en_w  (hz.wr_enW),
      .wr_addr_w(hz.wr_addrW),
      .fwd_sel_c(sel[p])
    );
  end

  always_comb begin
    fwd_flat = '0;
    for (int p = 0; p < NUM_RD_PORTS; p++) fwd_flat[p*2 +: 2] = sel[p];
  end
  assign hz.fwd_selE = fwd_flat;

  // D-stage source matches against the E-stage load and the scoreboard entry
  always_comb begin
    lu_match = 1'b0;
    sb_match = 1'b0;
    for (int p = 0; p < NUM_RD_PORTS; p++) begin
      if (hz.src_addrD[p*REG_AW +: REG_AW] != '0) begin
        if (hz.src_addrD[p*REG_AW +: REG_AW] == hz.wr_addrE) lu_match = 1'b1;
        if (hz.src_addrD[p*REG_AW +: REG_AW] == busy_dst)    sb_match = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= LS_IDLE;
      busy_dst <= '0;
    end else begin
      state    <= state_nxt;
      busy_dst <= busy_dst_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    busy_dst_nxt = busy_dst;
    relaunch     = 1'b0;
    case (state)
      LS_IDLE: begin
        if (start_ok) begin
          state_nxt    = LS_BUSY;
          busy_dst_nxt = hz.long_dstE;
        end
      end
      LS_BUSY: begin
        if (hz.flush_excM) begin
          state_nxt    = LS_IDLE;
          busy_dst_nxt = '0;
        end else if (hz.long_done) begin
          if (start_ok) begin
            relaunch     = 1'b1;
            busy_dst_nxt = hz.long_dstE;
          end else begin
            state_nxt    = LS_IDLE;
            busy_dst_nxt = '0;
          end
        end
      end
      default: begin
        state_nxt    = LS_IDLE;
        busy_dst_nxt = '0;
      end
    endcase
  end

  always_comb begin
    long_busy  = (state == LS_BUSY);
    load_use   = hz.is_loadE & hz.wr_enE & lu_match;
    sb_hit     = long_busy & sb_match;
    struct_haz = hz.long_startE & long_busy & ~hz.long_done;
    hard       = hz.i_stall | hz.d_stall | struct_haz;

    hz.stallW = hard;
    hz.stallM = hard;
    hz.stallE = hard;
    hz.stallD = hard | load_use | sb_hit;
    hz.stallF = ~hz.flush_excM & (hard | ((load_use | sb_hit) & ~hz.flush_predM));

    hz.flushF = 1'b0;
    hz.flushW = 1'b0;
    hz.flushM = hz.flush_excM;
    hz.flushE = hz.flush_excM | (hz.flush_predM & ~hard) | ((load_use | sb_hit) & ~hard);
    hz.flushD = hz.flush_excM | (hz.flush_predM & ~hard)
              | (hz.flush_jumpE & ~hard & ~load_use & ~sb_hit);

    start_ok     = hz.long_startE & ~hz.stallE & ~hz.flushE & ~hz.flush_excM;
    hz.long_busy = long_busy;
    hz.lat_err   = lat_err;
  end

  // Watchdog restarts for every op; lat_err stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wdog    <= '0;
      lat_err <= 1'b0;
    end else if (long_busy && (state_nxt == LS_BUSY) && !relaunch) begin
      if (wdog != WDOG_W'(WDOG_MAX)) wdog <= wdog + WDOG_W'(1);
      if (wdog == WDOG_W'(WDOG_MAX - 1)) lat_err <= 1'b1;
    end else begin
      wdog <= '0;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      hz.perf_lu_cnt  <= '0;
      hz.perf_sb_cnt  <= '0;
      hz.perf_mem_cnt <= '0;
    end else begin
      if (load_use)                hz.perf_lu_cnt  <= hz.perf_lu_cnt + PERF_W'(1);
      if (sb_hit)                  hz.perf_sb_cnt  <= hz.perf_sb_cnt + PERF_W'(1);
      if (hz.i_stall | hz.d_stall) hz.perf_mem_cnt <= hz.perf_mem_cnt + PERF_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard_unit.sv
// Directed bench for hazard_scoreboard_unit: comb vector table plus long-op sequences.
module tb_hazard_scoreboard_unit;

  localparam int unsigned WDOG_MAX = 40;
  localparam int NV = 19;

  typedef struct packed {
    logic [9:0] src_d;
    logic [9:0] src_e;
    logic       wr_en_e;
    logic [4:0] wr_addr_e;
    logic       wr_en_m;
    logic [4:0] wr_addr_m;
    logic       wr_en_w;
    logic [4:0] wr_addr_w;
    logic       is_load;
    logic       i_st;
    logic       d_st;
    logic       f_jump;
    logic       f_pred;
    logic       f_exc;
    logic [3:0] ex_fwd;
    logic [4:0] ex_stall;  // {F,D,E,M,W}
    logic [4:0] ex_flush;  // {F,D,E,M,W}
  } vec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   ncmp = 0;
  int   nerr = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  hazard_scoreboard_unit_if hz ();

  hazard_scoreboard_unit #(.WDOG_MAX(WDOG_MAX)) dut (
    .clk(clk),
    .rst(rst),
    .hz (hz)
  );

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s[%0d]: got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  function automatic logic [4:0] stalls();
    return {hz.stallF, hz.stallD, hz.stallE, hz.stallM, hz.stallW};
  endfunction

  function automatic logic [4:0] flushes();
    return {hz.flushF, hz.flushD, hz.flushE, hz.flushM, hz.flushW};
  endfunction

  task automatic clear_inputs();
    hz.src_addrD = '0; hz.src_addrE = '0;
    hz.wr_enE = 0; hz.wr_enM = 0; hz.wr_enW = 0;
    hz.wr_addrE = '0; hz.wr_addrM = '0; hz.wr_addrW = '0;
    hz.is_loadE = 0; hz.long_startE = 0; hz.long_dstE = '0; hz.long_done = 0;
    hz.i_stall = 0; hz.d_stall = 0;
    hz.flush_jumpE = 0; hz.flush_predM = 0; hz.flush_excM = 0;
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    clear_inputs();

    vecs[0]  = '{default: '0};
    vecs[1]  = '{src_e: {5'd0, 5'd8}, wr_en_m: 1'b1, wr_addr_m: 5'd8, wr_en_w: 1'b1, wr_addr_w: 5'd8,
                 ex_fwd: 4'b0001, default: '0};
    vecs[2]  = '{src_e: {5'd5, 5'd0}, wr_en_m: 1'b1, wr_addr_m: 5'd0, wr_en_w: 1'b1, wr_addr_w: 5'd5,
                 ex_fwd: 4'b1000, default: '0};
    vecs[3]  = '{src_e: {5'd4, 5'd3}, wr_en_m: 1'b1, wr_addr_m: 5'd4, wr_en_w: 1'b1, wr_addr_w: 5'd3,
                 ex_fwd: 4'b0110, default: '0};
    vecs[4]  = '{src_e: {5'd0, 5'd7}, wr_en_m: 1'b0, wr_addr_m: 5'd7, wr_en_w: 1'b1, wr_addr_w: 5'd7,
                 ex_fwd: 4'b0010, default: '0};
    vecs[5]  = '{src_d: {5'd9, 5'd0}, is_load: 1'b1, wr_en_e: 1'b1, wr_addr_e: 5'd9,
                 ex_stall: 5'b11000, ex_flush: 5'b00100, default: '0};
    vecs[6]  = '{src_d: {5'd9, 5'd0}, is_load: 1'b1, wr_en_e: 1'b0, wr_addr_e: 5'd9, default: '0};
    vecs[7]  = '{src_d: {5'd9, 5'd0}, is_load: 1'b0, wr_en_e: 1'b1, wr_addr_e: 5'd9, default: '0};
    vecs[8]  = '{src_d: {5'd0, 5'd0}, is_load: 1'b1, wr_en_e: 1'b1, wr_addr_e: 5'd0, default: '0};
    vecs[9]  = '{i_st: 1'b1, ex_stall: 5'b11111, default: '0};
    vecs[10] = '{d_st: 1'b1, f_pred: 1'b1, ex_stall: 5'b11111, default: '0};
    vecs[11] = '{f_pred: 1'b1, ex_flush: 5'b01100, default: '0};
    vecs[12] = '{f_jump: 1'b1, ex_flush: 5'b01000, default: '0};
    vecs[13] = '{src_d: {5'd0, 5'd9}, is_load: 1'b1, wr_en_e: 1'b1, wr_addr_e: 5'd9, f_jump: 1'b1,
                 ex_stall: 5'b11000, ex_flush: 5'b00100, default: '0};
    vecs[14] = '{f_exc: 1'b1, ex_flush: 5'b01110, default: '0};
    vecs[15] = '{src_d: {5'd0, 5'd9}, is_load: 1'b1, wr_en_e: 1'b1, wr_addr_e: 5'd9, f_exc: 1'b1,
                 ex_stall: 5'b01000, ex_flush: 5'b01110, default: '0};
    vecs[16] = '{src_d: {5'd0, 5'd9}, is_load: 1'b1, wr_en_e: 1'b1, wr_addr_e: 5'd9, f_pred: 1'b1,
                 ex_stall: 5'b01000, ex_flush: 5'b01100, default: '0};
    vecs[17] = '{i_st: 1'b1, f_exc: 1'b1, ex_stall: 5'b01111, ex_flush: 5'b01110, default: '0};
    vecs[18] = '{src_e: {5'd9, 5'd0}, wr_en_w: 1'b1, wr_addr_w: 5'd9, ex_fwd: 4'b1000, default: '0};

    // Reset state
    cyc(); cyc();
    rst = 0;
    settle();
    chk("rst_busy", 0, 32'(hz.long_busy), 32'd0);
    chk("rst_lat_err", 0, 32'(hz.lat_err), 32'd0);
    chk("rst_stall", 0, 32'(stalls()), 32'd0);
    chk("rst_flush", 0, 32'(flushes()), 32'd0);
    chk("rst_fwd", 0, 32'(hz.fwd_selE), 32'd0);

    // Combinational vector table with the scoreboard idle
    for (int i = 0; i < NV; i++) begin
      settle();
      hz.src_addrD = vecs[i].src_d;     hz.src_addrE = vecs[i].src_e;
      hz.wr_enE = vecs[i].wr_en_e;      hz.wr_addrE = vecs[i].wr_addr_e;
      hz.wr_enM = vecs[i].wr_en_m;      hz.wr_addrM = vecs[i].wr_addr_m;
      hz.wr_enW = vecs[i].wr_en_w;      hz.wr_addrW = vecs[i].wr_addr_w;
      hz.is_loadE = vecs[i].is_load;
      hz.i_stall = vecs[i].i_st;        hz.d_stall = vecs[i].d_st;
      hz.flush_jumpE = vecs[i].f_jump;  hz.flush_predM = vecs[i].f_pred;
      hz.flush_excM = vecs[i].f_exc;
      #1;
      chk("vec_fwd", i, 32'(hz.fwd_selE), 32'(vecs[i].ex_fwd));
      chk("vec_stall", i, 32'(stalls()), 32'(vecs[i].ex_stall));
      chk("vec_flush", i, 32'(flushes()), 32'(vecs[i].ex_flush));
    end
    clear_inputs();

    // Long op: D-stage reader of r2 stalls until the cycle after long_done
    cyc();
    hz.long_startE = 1; hz.long_dstE = 5'd2;
    settle();
    chk("lo_start_busy", 0, 32'(hz.long_busy), 32'd0);
    chk("lo_start_stall", 0, 32'(stalls()), 32'd0);
    cyc();
    hz.long_startE = 0; hz.long_dstE = '0; hz.src_addrD = {5'd0, 5'd2};
    for (int t = 1; t <= 4; t++) begin
      settle();
      chk("lo_busy", t, 32'(hz.long_busy), 32'd1);
      chk("lo_stall", t, 32'(stalls()), 32'b11000);
      chk("lo_flush", t, 32'(flushes()), 32'b00100);
      cyc();
    end
    hz.long_done = 1;
    settle();
    chk("lo_done_stall", 5, 32'(stalls()), 32'b11000);
    cyc();
    hz.long_done = 0;
    settle();
    chk("lo_rel_busy", 6, 32'(hz.long_busy), 32'd0);
    chk("lo_rel_stall", 6, 32'(stalls()), 32'd0);
    chk("lo_rel_flush", 6, 32'(flushes()), 32'd0);

    // Structural: second long op waits for long_done, then takes the scoreboard
    clear_inputs();
    hz.long_startE = 1; hz.long_dstE = 5'd2;
    cyc();
    hz.long_dstE = 5'd5;
    for (int t = 0; t < 3; t++) begin
      settle();
      chk("st_stall", t, 32'(stalls()), 32'b11111);
      chk("st_flush", t, 32'(flushes()), 32'd0);
      cyc();
    end
    hz.long_done = 1;
    settle();
    chk("st_done_stall", 0, 32'(stalls()), 32'd0);
    cyc();
    hz.long_done = 0; hz.long_startE = 0; hz.long_dstE = '0;
    hz.src_addrD = {5'd5, 5'd0};
    settle();
    chk("st_new_busy", 0, 32'(hz.long_busy), 32'd1);
    chk("st_new_dst_hit", 0, 32'(hz.stallD), 32'd1);
    hz.src_addrD = {5'd0, 5'd2};
    #1;
    chk("st_old_dst_miss", 0, 32'(hz.stallD), 32'd0);

    // Exception abort while busy; stray long_done afterwards is ignored
    cyc();
    hz.src_addrD = {5'd0, 5'd5}; hz.flush_excM = 1;
    settle();
    chk("exc_stall", 0, 32'(stalls()), 32'b01000);
    chk("exc_flush", 0, 32'(flushes()), 32'b01110);
    cyc();
    hz.flush_excM = 0; hz.long_done = 1;
    settle();
    chk("exc_idle", 0, 32'(hz.long_busy), 32'd0);
    chk("exc_no_sb", 0, 32'(stalls()), 32'd0);
    cyc();
    hz.long_done = 0;
    settle();
    chk("exc_stray_idle", 0, 32'(hz.long_busy), 32'd0);

    // Watchdog trips after WDOG_MAX busy cycles, stays sticky, cleared only by reset
    clear_inputs();
    hz.long_startE = 1; hz.long_dstE = 5'd3;
    cyc();
    hz.long_startE = 0; hz.long_dstE = '0;
    repeat (WDOG_MAX - 1) cyc();
    settle();
    chk("wd_pre_err", 0, 32'(hz.lat_err), 32'd0);
    chk("wd_pre_busy", 0, 32'(hz.long_busy), 32'd1);
    cyc();
    settle();
    chk("wd_err", 0, 32'(hz.lat_err), 32'd1);
    chk("wd_fsm_busy", 0, 32'(hz.long_busy), 32'd1);
    cyc();
    hz.long_done = 1;
    cyc();
    hz.long_done = 0;
    settle();
    chk("wd_sticky_err", 0, 32'(hz.lat_err), 32'd1);
    chk("wd_done_idle", 0, 32'(hz.long_busy), 32'd0);
    cyc();
    hz.long_startE = 1; hz.long_dstE = 5'd3;
    cyc();
    hz.long_startE = 0; hz.long_dstE = '0;
    settle();
    chk("rb_busy", 0, 32'(hz.long_busy), 32'd1);
    cyc();
    rst = 1;
    cyc();
    rst = 0;
    settle();
    chk("rb_busy_clr", 0, 32'(hz.long_busy), 32'd0);
    chk("rb_err_clr", 0, 32'(hz.lat_err), 32'd0);
    cyc();
    hz.long_done = 1;
    cyc();
    hz.long_done = 0;
    settle();
    chk("rb_stray_idle", 0, 32'(hz.long_busy), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
